// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
// Segment encoding is {dp,g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  typedef enum logic {
    S_BLANK,
    S_ON
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ca_dec.sv
// Combinational nibble to active-low segment decoder.
// Shared by every digit through the scan mux.
module hex_to_seg_ca
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seven_seg_scan_ca.sv
// Multiplexed common-anode display driver: prescaler, blanking,
// frame-synchronous data update and leading-zero blanking.
module seven_seg_scan_ca
  import seven_seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb_en,
  output logic [7:0]            hex,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(DIGITS);
  localparam int DW   = 4 * DIGITS;

  scan_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;

  logic [DW-1:0]     pend_data, disp_data;
  logic [DIGITS-1:0] pend_dp, disp_dp;
  logic              pend_vld;

  logic last_blank, last_on, boundary;

  logic [DIGITS-1:0] lead_zero;
  logic [3:0]        nib;
  logic              dp_sel;
  logic              blank_sel;
  logic [6:0]        seg7;
  seg_t              hex_n;
  logic [DIGITS-1:0] an_n;

  assign last_blank = (state == S_BLANK) && (cnt == CW'(BLANK - 1));
  assign last_on    = (state == S_ON) && (cnt == CW'(DWELL - 1));
  assign boundary   = last_on && (idx == IW'(DIGITS - 1));

  // Scan state, counter and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next scan position: blank gap, then dwell, then next digit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    unique case (state)
      S_BLANK: begin
        if (last_blank) begin
          state_n = S_ON;
          cnt_n   = '0;
        end
      end
      S_ON: begin
        if (last_on) begin
          state_n = S_BLANK;
          cnt_n   = '0;
          if (idx == IW'(DIGITS - 1)) begin
            idx_n = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: begin
        state_n = S_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // Pick the nibble/dp for the upcoming digit and its leading-zero status.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    lead_zero = '0;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc && (disp_data[4*i +: 4] == 4'h0);
      lead_zero[i] = acc;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        nib       = disp_data[4*i +: 4];
        dp_sel    = disp_dp[i];
        blank_sel = lzb_en && (i != 0) && lead_zero[i];
      end
    end
  end

  hex_to_seg_ca u_dec (
    .nibble (nib),
    .seg    (seg7)
  );

  // Output values for the state being entered on this edge.
  always_comb begin
    hex_n = SEG_OFF;
    an_n  = '1;
    if (state_n == S_ON) begin
      hex_n = {~dp_sel, blank_sel ? 7'h7F : seg7};
      for (int i = 0; i < DIGITS; i++) begin
        an_n[i] = (idx_n != IW'(i));
      end
    end
  end

  // Registered pins move on the same edge as the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      hex        <= hex_n;
      an         <= an_n;
      frame_done <= boundary;
    end
  end

  // Pending capture and tear-free promotion at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_vld  <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else if (boundary) begin
      if (load) begin
        disp_data <= data_in;
        disp_dp   <= dp_in;
      end else if (pend_vld) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_data <= data_in;
      pend_dp   <= dp_in;
      pend_vld  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ca.sv
// Self-checking bench for seven_seg_scan_ca (4 digits, dwell 4, blank 2).
// Reference model works in whole frames and slots by elapsed-cycle arithmetic.
module tb_seven_seg_scan_ca;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = DWELL + BLANK;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        lzb_en = 1'b0;
  logic [7:0]  hex;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int t = 0;

  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_vld;
  logic [3:0]  exp_an;
  logic [7:0]  exp_hex;
  logic        exp_fd;

  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seven_seg_scan_ca #(
    .DIGITS (DIGITS),
    .DWELL  (DWELL),
    .BLANK  (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .lzb_en     (lzb_en),
    .hex        (hex),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_an t=%0d an=%b", t, an);
      end
    end
  end

  task automatic model_reset();
    t      = 0;
    m_disp = '0;
    m_dp   = '0;
    m_pend = '0;
    m_pdp  = '0;
    m_vld  = 1'b0;
  endtask

  function automatic void calc_exp();
    int dig, off;
    logic [15:0] sh;
    logic [7:0]  g;
    dig    = (t / SLOT) % DIGITS;
    off    = t % SLOT;
    exp_fd = (t > 0) && (t % FRAME == 0);
    if (off < BLANK) begin
      exp_an  = 4'hF;
      exp_hex = 8'hFF;
    end else begin
      exp_an  = 4'hF & ~(4'b0001 << dig);
      sh      = m_disp >> (4 * dig);
      g       = glyph[sh[3:0]];
      if (lzb_en && dig != 0 && sh == 16'h0) g = 8'hFF;
      exp_hex = {~m_dp[dig], g[6:0]};
    end
  endfunction

  task automatic tick(input logic ld, input logic [15:0] d,
                      input logic [3:0] p);
    load    = ld;
    data_in = d;
    dp_in   = p;
    @(posedge clk);
    if (t % FRAME == FRAME - 1) begin
      if (ld) begin
        m_disp = d;
        m_dp   = p;
      end else if (m_vld) begin
        m_disp = m_pend;
        m_dp   = m_pdp;
      end
      m_vld = 1'b0;
    end else if (ld) begin
      m_pend = d;
      m_pdp  = p;
      m_vld  = 1'b1;
    end
    t++;
    @(negedge clk);
    load = 1'b0;
    calc_exp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (hex !== 8'hFF) begin
      errors++;
      $display("FAIL reset_hex got %h exp ff", hex);
    end
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL reset_an got %h exp f", an);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd got %b exp 0", frame_done);
    end
    rst = 1'b0;
    model_reset();
    calc_exp();
  endtask

  task automatic run(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL %s_an t=%0d got %h exp %h", name, t, an, exp_an);
      end
      checks++;
      if (hex !== exp_hex) begin
        errors++;
        $display("FAIL %s_hex t=%0d got %h exp %h", name, t, hex, exp_hex);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL %s_fd t=%0d got %b exp %b", name, t,
                 frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] seq [12];
    int fd_cnt;
    seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
            4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 16'h0, 4'h0);
      checks++;
      if (an !== seq[(k + 1) % 12]) begin
        errors++;
        $display("FAIL scan_seq k=%0d got %h exp %h", k, an,
                 seq[(k + 1) % 12]);
      end
    end
    fd_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick(1'b0, 16'h0, 4'h0);
      if (frame_done) fd_cnt++;
      checks++;
      if (an !== exp_an || hex !== exp_hex) begin
        errors++;
        $display("FAIL scan t=%0d got %h/%h exp %h/%h", t, an, hex,
                 exp_an, exp_hex);
      end
    end
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL scan_fd_count got %0d exp 2", fd_cnt);
    end
  endtask

  task automatic test_load();
    run("pre", 5);
    tick(1'b1, 16'h12AF, 4'h0);
    run("load", 2 * FRAME);
  endtask

  task automatic test_lzb();
    lzb_en = 1'b1;
    tick(1'b1, 16'h0050, 4'h0);
    run("lzb50", 2 * FRAME);
    tick(1'b1, 16'h0000, 4'h0);
    run("lzb0", 2 * FRAME);
    lzb_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 16'h1234, 4'h3);
    for (int k = 0; k < FRAME && (t % FRAME) != FRAME - 1; k++) begin
      tick(1'b0, 16'h0, 4'h0);
    end
    tick(1'b1, 16'hBEEF, 4'h0);
    run("beef", 2 * FRAME);
    tick(1'b1, 16'h1111, 4'h1);
    run("two", 4);
    tick(1'b1, 16'h2222, 4'h2);
    run("two", 2 * FRAME);
  endtask

  task automatic test_dp();
    tick(1'b1, 16'h0000, 4'b0100);
    run("dp", FRAME);
    for (int k = 0; k < FRAME; k++) begin
      tick(1'b0, 16'h0, 4'h0);
      checks++;
      if ((hex[7] === 1'b0) !== (an === 4'hB)) begin
        errors++;
        $display("FAIL dp_only_b t=%0d got an=%h hex=%h", t, an, hex);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 9) == 0) begin
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
        tick(1'b1, d, 4'($urandom));
      end else begin
        tick(1'b0, 16'h0, 4'h0);
      end
      checks++;
      if (an !== exp_an || hex !== exp_hex || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL rand t=%0d got %h/%h/%b exp %h/%h/%b", t, an, hex,
                 frame_done, exp_an, exp_hex, exp_fd);
      end
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 16'h9876, 4'hF);
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ((t / SLOT) % DIGITS == 2 && (t % FRAME) > FRAME) break;
      if ((t / SLOT) % DIGITS == 2 && (t % SLOT) == BLANK + 1 &&
          t > FRAME) break;
      tick(1'b0, 16'h0, 4'h0);
    end
    checks++;
    if (an !== 4'hB) begin
      errors++;
      $display("FAIL mid_pre_an got %h exp b", an);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || hex !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got %h/%h/%b exp f/ff/0", an, hex,
               frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    calc_exp();
    run("restart", FRAME + 4);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_lzb();
    test_back_to_back();
    test_dp();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
